// File: rtl/alu_seq.sv
// Registered execute-stage ALU: single-cycle logic/arithmetic ops plus a
// multi-cycle unsigned shift-add multiplier (MUL low half, UMULH high half).
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned MUL_K = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       exe_cmd,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [3:0]       sr_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       status
);

    localparam int unsigned N_STEPS = WIDTH / MUL_K;
    localparam int unsigned CNT_W   = $clog2(N_STEPS + 1);
    localparam int unsigned PW      = 2 * WIDTH;

    localparam logic [3:0] CMD_MOV   = 4'b0001;
    localparam logic [3:0] CMD_ADD   = 4'b0010;
    localparam logic [3:0] CMD_ADC   = 4'b0011;
    localparam logic [3:0] CMD_SUB   = 4'b0100;
    localparam logic [3:0] CMD_SBC   = 4'b0101;
    localparam logic [3:0] CMD_AND   = 4'b0110;
    localparam logic [3:0] CMD_ORR   = 4'b0111;
    localparam logic [3:0] CMD_EOR   = 4'b1000;
    localparam logic [3:0] CMD_MVN   = 4'b1001;
    localparam logic [3:0] CMD_MUL   = 4'b1010;
    localparam logic [3:0] CMD_UMULH = 4'b1011;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       status_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [3:0]       cmd_q;
    logic [CNT_W-1:0] cnt_q;

    logic             carry_in;
    logic             borrow_in;
    logic [WIDTH:0]   ext_c;
    logic [WIDTH-1:0] alu_res_c;
    logic             alu_c_c;
    logic             alu_v_c;
    logic [3:0]       alu_status_c;
    logic             is_mul_c;
    logic [MUL_K-1:0] digit_c;
    logic [PW-1:0]    partial_c;
    logic [PW-1:0]    acc_nx_c;
    logic [WIDTH-1:0] mul_res_c;
    logic             unused_c;

    // Only the carry flag of the incoming status feeds the datapath.
    assign carry_in  = sr_in[1];
    assign borrow_in = ~carry_in;
    assign unused_c  = ^{sr_in[3:2], sr_in[0]};

    // Single-cycle ops; sums/differences carried at WIDTH+1 bits.
    always_comb begin
        ext_c     = '0;
        alu_res_c = '0;
        alu_c_c   = 1'b0;
        alu_v_c   = 1'b0;
        case (exe_cmd)
            CMD_MOV: alu_res_c = val2;
            CMD_MVN: alu_res_c = ~val2;
            CMD_AND: alu_res_c = val1 & val2;
            CMD_ORR: alu_res_c = val1 | val2;
            CMD_EOR: alu_res_c = val1 ^ val2;
            CMD_ADD, CMD_ADC: begin
                ext_c = {1'b0, val1} + {1'b0, val2}
                      + ((exe_cmd == CMD_ADC) ? (WIDTH+1)'(carry_in) : (WIDTH+1)'(0));
                alu_res_c = ext_c[WIDTH-1:0];
                alu_c_c   = ext_c[WIDTH];
                alu_v_c   = (val1[WIDTH-1] == val2[WIDTH-1]) && (ext_c[WIDTH-1] != val1[WIDTH-1]);
            end
            CMD_SUB, CMD_SBC: begin
                ext_c = {1'b0, val1} - {1'b0, val2}
                      - ((exe_cmd == CMD_SBC) ? (WIDTH+1)'(borrow_in) : (WIDTH+1)'(0));
                alu_res_c = ext_c[WIDTH-1:0];
                alu_c_c   = ext_c[WIDTH];
                alu_v_c   = (val1[WIDTH-1] != val2[WIDTH-1]) && (ext_c[WIDTH-1] != val1[WIDTH-1]);
            end
            default: alu_res_c = '0;
        endcase
    end

    assign alu_status_c = {alu_res_c[WIDTH-1], alu_res_c == '0, alu_c_c, alu_v_c};
    assign is_mul_c     = (exe_cmd == CMD_MUL) || (exe_cmd == CMD_UMULH);

    // Multiplicand pre-shifted each step, so each digit's partial lands at its offset.
    assign digit_c   = mplier_q[MUL_K-1:0];
    assign partial_c = mcand_q * PW'(digit_c);
    assign acc_nx_c  = acc_q + partial_c;
    assign mul_res_c = (cmd_q == CMD_UMULH) ? acc_nx_c[PW-1:WIDTH] : acc_nx_c[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            status_q <= 4'b0100;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cmd_q    <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (is_mul_c) begin
                            state_q  <= S_MUL;
                            busy_q   <= 1'b1;
                            mcand_q  <= PW'(val1);
                            mplier_q <= val2;
                            cmd_q    <= exe_cmd;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                        end else begin
                            result_q <= alu_res_c;
                            status_q <= alu_status_c;
                            done_q   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_nx_c;
                    mcand_q  <= mcand_q << MUL_K;
                    mplier_q <= mplier_q >> MUL_K;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(N_STEPS - 1)) begin
                        result_q <= mul_res_c;
                        status_q <= {mul_res_c[WIDTH-1], mul_res_c == '0, 2'b00};
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign status = status_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a 32-bit/1-bit-per-step instance for directed
// tests and a 16-bit/4-bit-per-step instance for the random multiply sweep.
module tb_alu_seq;

    localparam logic [3:0] C_MOV = 4'b0001, C_ADD = 4'b0010, C_ADC = 4'b0011,
                           C_SUB = 4'b0100, C_SBC = 4'b0101, C_AND = 4'b0110,
                           C_ORR = 4'b0111, C_EOR = 4'b1000, C_MVN = 4'b1001,
                           C_MUL = 4'b1010, C_UMH = 4'b1011, C_BAD = 4'b1111;

    logic        clk = 1'b0;
    logic        rst;
    logic        start32, busy32, done32;
    logic [3:0]  cmd32, sr32, st32;
    logic [31:0] a32, b32, res32;
    logic        start16, busy16, done16;
    logic [3:0]  cmd16, sr16, st16;
    logic [15:0] a16, b16, res16;

    int checks = 0;
    int errors = 0;
    logic [35:0] sb32[$];
    logic [35:0] sb16[$];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .MUL_K(1)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .exe_cmd(cmd32), .val1(a32), .val2(b32),
        .sr_in(sr32), .busy(busy32), .done(done32), .result(res32), .status(st32)
    );

    alu_seq #(.WIDTH(16), .MUL_K(4)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .exe_cmd(cmd16), .val1(a16), .val2(b16),
        .sr_in(sr16), .busy(busy16), .done(done16), .result(res16), .status(st16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent multiply reference using 64-bit arithmetic.
    function automatic logic [35:0] ref_mul(input int w, input logic [3:0] cmd,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p, mask, r;
        p    = 64'(a) * 64'(b);
        mask = (64'd1 << w) - 64'd1;
        r    = (cmd == C_UMH) ? ((p >> w) & mask) : (p & mask);
        return {r[w-1], r == 64'd0, 2'b00, r[31:0]};
    endfunction

    // Issue one op on the 32-bit DUT at a negedge, wait for done, compare.
    task automatic run32(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic cin, input logic [31:0] er,
                         input logic [3:0] es, input int elat, input bit interfere);
        int lat, busy_n;
        logic [31:0] prev;
        logic [35:0] exp;
        prev = res32;
        start32 = 1'b1; cmd32 = cmd; a32 = a; b32 = b; sr32 = {2'b00, cin, 1'b0};
        sb32.push_back({es, er});
        lat = 0; busy_n = 0;
        do begin
            @(negedge clk);
            lat++;
            start32 = 1'b0;
            if (interfere && lat == 3) begin
                start32 = 1'b1; cmd32 = C_ADD; a32 = 32'h100; b32 = 32'h200;
            end
            if (interfere && lat == 6) begin
                a32 = $urandom; b32 = $urandom; sr32 = 4'hF;
            end
            if (busy32) busy_n++;
            if (elat > 2 && lat == 2) chk({tag, " hold"}, 64'(res32), 64'(prev));
        end while (!done32 && lat < 200);
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        if (elat > 1) chk({tag, " busy"}, 64'(busy_n), 64'(elat - 1));
        exp = sb32.pop_front();
        chk({tag, " result"}, 64'(res32), 64'(exp[31:0]));
        chk({tag, " status"}, 64'(st32), 64'(exp[35:32]));
    endtask

    task automatic run16(input string tag, input logic [3:0] cmd, input logic [15:0] a,
                         input logic [15:0] b, input logic [35:0] e, input int elat);
        int lat;
        logic [35:0] exp;
        start16 = 1'b1; cmd16 = cmd; a16 = a; b16 = b; sr16 = 4'h0;
        sb16.push_back(e);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start16 = 1'b0;
        end while (!done16 && lat < 100);
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        exp = sb16.pop_front();
        chk({tag, " result"}, 64'(res16), 64'(exp[15:0]));
        chk({tag, " status"}, 64'(st16), 64'(exp[35:32]));
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [3:0]  rc;
        rst = 1'b1;
        start32 = 1'b0; cmd32 = '0; a32 = '0; b32 = '0; sr32 = '0;
        start16 = 1'b0; cmd16 = '0; a16 = '0; b16 = '0; sr16 = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(busy32), 64'(0));
        chk("rst done", 64'(done32), 64'(0));
        chk("rst result", 64'(res32), 64'(0));
        chk("rst status", 64'(st32), 64'(4'b0100));
        chk("rst16 status", 64'(st16), 64'(4'b0100));
        rst = 1'b0;

        run32("add ovf",  C_ADD, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 4'b1001, 1, 0);
        run32("sub brw",  C_SUB, 32'h0, 32'h1, 1'b0, 32'hFFFFFFFF, 4'b1010, 1, 0);
        run32("sub ovf",  C_SUB, 32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 4'b0001, 1, 0);
        run32("sbc",      C_SBC, 32'h5, 32'h3, 1'b0, 32'h1, 4'b0000, 1, 0);
        run32("adc wrap", C_ADC, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 4'b0110, 1, 0);
        run32("mov",      C_MOV, 32'h1234, 32'h0, 1'b1, 32'h0, 4'b0100, 1, 0);
        run32("mvn",      C_MVN, 32'h0, 32'h0, 1'b0, 32'hFFFFFFFF, 4'b1000, 1, 0);
        run32("and",      C_AND, 32'hF0F0, 32'hFF00, 1'b0, 32'hF000, 4'b0000, 1, 0);
        run32("orr",      C_ORR, 32'hF0F0, 32'h0F0F, 1'b0, 32'hFFFF, 4'b0000, 1, 0);
        run32("eor",      C_EOR, 32'hFFFF, 32'hFFFF, 1'b0, 32'h0, 4'b0100, 1, 0);
        run32("undef",    C_BAD, 32'h5, 32'h7, 1'b1, 32'h0, 4'b0100, 1, 0);

        run32("mul 7x6",  C_MUL, 32'd7, 32'd6, 1'b0, 32'd42, 4'b0000, 33, 0);
        run32("umulh max", C_UMH, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 4'b1000, 33, 0);
        run32("mul max",  C_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h1, 4'b0000, 33, 0);
        run32("mul zero", C_MUL, 32'h0, 32'h12345, 1'b0, 32'h0, 4'b0100, 33, 0);

        // Start and operand changes during busy must be ignored.
        run32("mul blk",  C_MUL, 32'd7, 32'd6, 1'b0, 32'd42, 4'b0000, 33, 1);
        @(negedge clk);
        chk("blk single done", 64'(done32), 64'(0));
        chk("blk held", 64'(res32), 64'(42));

        // ADD issued in the very cycle the multiply completes.
        run32("mul b2b",  C_MUL, 32'd9, 32'd5, 1'b0, 32'd45, 4'b0000, 33, 0);
        run32("add b2b",  C_ADD, 32'd2, 32'd3, 1'b0, 32'd5, 4'b0000, 1, 0);

        // Asynchronous reset in the middle of a multiply.
        start32 = 1'b1; cmd32 = C_MUL; a32 = 32'd3; b32 = 32'd5;
        @(negedge clk);
        start32 = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-rst busy", 64'(busy32), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("async busy", 64'(busy32), 64'(0));
        chk("async done", 64'(done32), 64'(0));
        chk("async result", 64'(res32), 64'(0));
        chk("async status", 64'(st32), 64'(4'b0100));
        @(negedge clk);
        rst = 1'b0;
        run32("add post-rst", C_ADD, 32'd1, 32'd1, 1'b0, 32'd2, 4'b0000, 1, 0);

        // Random multiply sweep, issued back-to-back.
        for (int i = 0; i < 1000; i++) begin
            ra = (i == 0) ? 16'hFFFF : 16'($urandom);
            rb = (i == 0) ? 16'hFFFF : 16'($urandom);
            if (i % 50 == 7) ra = 16'h0;
            rc = ($urandom_range(0, 1) == 0) ? C_MUL : C_UMH;
            run16("sweep", rc, ra, rb, ref_mul(16, rc, 32'(ra), 32'(rb)), 5);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
